// File: rtl/shift_mult_ctrl.sv
// Multi-cycle signed WIDTH x WIDTH shift-and-add multiplier sequencer with start/ready handshake.
// Optional macro EARLY_TERM_EN finishes as soon as the remaining multiplier bits are all zero.
module shift_mult_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [1:0]           state_reg;
    logic [CNT_W-1:0]     count_reg;
    logic [2*WIDTH-1:0]   mcand_reg;
    logic [2*WIDTH-1:0]   acc_reg;
    logic [WIDTH-1:0]     mplier_reg;
    logic [WIDTH-1:0]     result_reg;
    logic                 exc_reg;
    logic                 rdy_reg;

    logic                 last_iter;
    logic                 run_end;
    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   acc_next;
    logic [WIDTH:0]       acc_upper;
    logic                 exc_next;

    assign last_iter = (count_reg == LAST_ITER);
    assign addend    = mplier_reg[0] ? mcand_reg : '0;
    // The multiplier MSB has negative weight, so the final partial product is subtracted.
    assign acc_next  = last_iter ? (acc_reg - addend) : (acc_reg + addend);

`ifdef EARLY_TERM_EN
    // Bits above the one consumed this cycle are zero: every later partial product is zero.
    assign run_end = last_iter || (mplier_reg[WIDTH-1:1] == '0);
`else
    assign run_end = last_iter;
`endif

    assign acc_upper = acc_reg[2*WIDTH-1:WIDTH-1];
    assign exc_next  = ~((acc_upper == '0) || (&acc_upper));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            count_reg  <= '0;
            mcand_reg  <= '0;
            acc_reg    <= '0;
            mplier_reg <= '0;
            result_reg <= '0;
            exc_reg    <= 1'b0;
            rdy_reg    <= 1'b0;
        end else begin
            rdy_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (ctrl_MULT) begin
                        mcand_reg  <= {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
                        mplier_reg <= data_operandB;
                        acc_reg    <= '0;
                        count_reg  <= '0;
                        result_reg <= '0;
                        exc_reg    <= 1'b0;
                        state_reg  <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc_reg    <= acc_next;
                    mcand_reg  <= {mcand_reg[2*WIDTH-2:0], 1'b0};
                    mplier_reg <= {1'b0, mplier_reg[WIDTH-1:1]};
                    count_reg  <= count_reg + 1'b1;
                    if (run_end) begin
                        state_reg <= S_DONE;
                    end
                end
                S_DONE: begin
                    result_reg <= acc_reg[WIDTH-1:0];
                    exc_reg    <= exc_next;
                    rdy_reg    <= 1'b1;
                    state_reg  <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign data_result    = result_reg;
    assign data_exception = exc_reg;
    assign data_resultRDY = rdy_reg;
    assign busy           = (state_reg != S_IDLE);

endmodule

// File: tb/tb_shift_mult_ctrl.sv
// Self-checking bench for shift_mult_ctrl: cycle-accurate behavioural model plus directed and random runs.
// Honours EARLY_TERM_EN so the same bench covers both builds.
module tb_shift_mult_ctrl;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             ctrl_MULT = 1'b0;
    logic [WIDTH-1:0] data_operandA = '0;
    logic [WIDTH-1:0] data_operandB = '0;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    int vectors = 0;
    int miscompares = 0;

    int               edge_n = 0;
    int               t0_drv = 0;
    int               txn = 0;

    // model state
    bit               m_active = 1'b0;
    int               m_t0 = 0;
    int               m_lat = 0;
    logic [WIDTH-1:0] m_res = '0;
    logic             m_exc = 1'b0;

    shift_mult_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clock          (clk),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %h, expected %h", name, edge_n, act, req);
        end
    endtask

    function automatic longint model_product(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return longint'($signed(a)) * longint'($signed(b));
    endfunction

    function automatic logic model_exc(input longint p);
        logic [WIDTH-1:0] lo;
        lo = p[WIDTH-1:0];
        return p != longint'($signed(lo));
    endfunction

    // Cycles from the accepting edge to the ready pulse.
    function automatic int model_lat(input logic [WIDTH-1:0] b);
`ifdef EARLY_TERM_EN
        int hi;
        hi = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (b[i]) hi = i;
        end
        return hi + 2;
`else
        return WIDTH + 1;
`endif
    endfunction

    always @(posedge clk) begin
        longint p;
        edge_n = edge_n + 1;
        if (reset) begin
            m_active = 1'b0;
            m_res    = '0;
            m_exc    = 1'b0;
        end else if (ctrl_MULT && (!m_active || (edge_n - 1 - m_t0) >= m_lat)) begin
            p        = model_product(data_operandA, data_operandB);
            m_active = 1'b1;
            m_t0     = edge_n;
            m_lat    = model_lat(data_operandB);
            m_res    = p[WIDTH-1:0];
            m_exc    = model_exc(p);
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        int  k;
        bit  e_busy;
        bit  e_rdy;
        if (reset) begin
            check("busy_rst", 64'(busy), 64'd0);
            check("rdy_rst", 64'(data_resultRDY), 64'd0);
            check("result_rst", 64'(data_result), 64'd0);
            check("exc_rst", 64'(data_exception), 64'd0);
        end else begin
            k      = edge_n - m_t0;
            e_busy = m_active && (k < m_lat);
            e_rdy  = m_active && (k == m_lat);
            check("busy", 64'(busy), 64'(e_busy));
            check("rdy", 64'(data_resultRDY), 64'(e_rdy));
            check("result", 64'(data_result), e_busy ? 64'd0 : 64'(m_res));
            check("exc", 64'(data_exception), e_busy ? 64'd0 : 64'(m_exc));
        end
    end

    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = 1'b1;
        @(posedge clk);
        #1;
        t0_drv = edge_n;
    endtask

    // junk_mode 0: quiet, 1: start attempt at cycle 10, 2: random start attempts.
    task automatic wait_rdy(input int junk_mode, output int lat);
        lat = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (data_resultRDY) begin
                lat       = edge_n - t0_drv;
                ctrl_MULT = 1'b0;
                return;
            end
            data_operandA = $urandom;
            data_operandB = $urandom;
            case (junk_mode)
                1:       ctrl_MULT = (k == 10);
                2:       ctrl_MULT = ($urandom_range(0, 3) == 0);
                default: ctrl_MULT = 1'b0;
            endcase
        end
        ctrl_MULT = 1'b0;
        vectors++;
        miscompares++;
        $display("FAIL rdy_timeout: got no data_resultRDY within 100 cycles, expected one");
    endtask

    task automatic run_dir(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] res, input logic exc,
                           input int lat_off, input int lat_on, input int junk_mode);
        int lat;
        start_op(a, b);
        wait_rdy(junk_mode, lat);
        check("dir_result", 64'(data_result), 64'(res));
        check("dir_exc", 64'(data_exception), 64'(exc));
`ifdef EARLY_TERM_EN
        check("dir_latency", 64'(lat), 64'(lat_on));
`else
        check("dir_latency", 64'(lat), 64'(lat_off));
`endif
        txn++;
        $display("txn %0d A=%h B=%h result=%h exc=%b lat=%0d", txn, a, b, data_result, data_exception, lat);
    endtask

    initial begin
        logic [WIDTH-1:0] corners [5];
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        longint           p;
        int               lat;

        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;

        // Start request and operands present while reset is held must be ignored.
        data_operandA = 32'd7;
        data_operandB = 32'd6;
        ctrl_MULT     = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_result", 64'(data_result), 64'd0);
        ctrl_MULT = 1'b0;
        #1 reset = 1'b0;

        run_dir(32'd7, 32'd6, 32'd42, 1'b0, 33, 4, 0);
        run_dir(32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0, 33, 4, 0);
        run_dir(32'd5, 32'hFFFF_FFFD, 32'hFFFF_FFF1, 1'b0, 33, 33, 0);
        run_dir(32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 33, 18, 0);
        run_dir(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33, 33, 0);
        run_dir(32'd0, 32'h1234_5678, 32'd0, 1'b0, 33, 30, 0);
        run_dir(32'h1234_5678, 32'd0, 32'd0, 1'b0, 33, 2, 0);
        run_dir(32'h0000_0009, 32'd1, 32'd9, 1'b0, 33, 2, 0);
        run_dir(32'd3, 32'h4000_0000, 32'hC000_0000, 1'b1, 33, 32, 0);

        // A start attempt mid-run is ignored; the next run begins in the ready cycle.
        run_dir(32'd1000, 32'hFFFF_FFFE, 32'hFFFF_F830, 1'b0, 33, 33, 1);
        run_dir(32'd12, 32'd12, 32'd144, 1'b0, 33, 5, 0);

        // Reset during RUN aborts; the next start completes normally.
        start_op(32'd77, 32'hFFFF_FFFF);
        repeat (15) @(negedge clk);
        ctrl_MULT = 1'b0;
        #1 reset = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_result", 64'(data_result), 64'd0);
        check("abort_rdy", 64'(data_resultRDY), 64'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        run_dir(32'd9, 32'hFFFF_FFF7, 32'hFFFF_FFAF, 1'b0, 33, 33, 0);

        for (int n = 0; n < 1000; n++) begin
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = 32'($urandom_range(0, 15)) - 32'd8; b = 32'($urandom_range(0, 15)) - 32'd8; end
                2: begin a = corners[$urandom_range(0, 4)]; b = corners[$urandom_range(0, 4)]; end
                default: begin a = $urandom; b = $urandom >> $urandom_range(1, 31); end
            endcase
            p = model_product(a, b);
            start_op(a, b);
            wait_rdy(2, lat);
            check("rnd_result", 64'(data_result), 64'(p[WIDTH-1:0]));
            check("rnd_exc", 64'(data_exception), 64'(model_exc(p)));
            check("rnd_latency", 64'(lat), 64'(model_lat(b)));
            txn++;
            $display("txn %0d A=%h B=%h result=%h exc=%b lat=%0d", txn, a, b, data_result, data_exception, lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
